logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit: WIDTH-bit operands a, b; 3-bit opcode selects one of eight gate functions.
- Two register stages with valid/ready handshake on input and output; full throughput of 1 op/cycle; stalls under backpressure without data loss.
- Also produces registered zero and parity flags.
- Sits between operand sources and any downstream consumer that needs a registered, flow-controlled bitwise result.

---
 rtl/logic_unit_pipe.sv | 168 ++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage, valid/ready flow-controlled bitwise logic unit.
// Stage 1 captures opcode and operands; stage 2 holds the result, plus zero
// and parity flags, and drives the consumer-facing outputs.
// Optional feature macro: LU_CHAIN_EN. When defined, a chain register keeps
// the last consumed result, and in_chain=1 substitutes it for operand b.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity
);

    // Stage 1 registers.
    logic             s1Valid_q, s1Valid_d;
    logic [2:0]       s1Op_q, s1Op_d;
    logic [WIDTH-1:0] s1A_q, s1A_d;
    logic [WIDTH-1:0] s1B_q, s1B_d;

    // Stage 2 registers, which drive the outputs.
    logic             s2Valid_q, s2Valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;

    // Handshake terms and datapath intermediates.
    logic             inXfer;
    logic             outXfer;
    logic             s2Load;
    logic [WIDTH-1:0] effB;
    logic [WIDTH-1:0] stageY;

    // Eight pure bitwise gate functions. There is no carry and no extension.
    function automatic logic [WIDTH-1:0] evalOp(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a | b;
            3'd1:    r = a & b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a | b);
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = a;
            default: r = ~a;
        endcase
        return r;
    endfunction

    // Handshake: stage 2 accepts when it is empty or being drained. Stage 1
    // frees up whenever it hands its op to stage 2, so in_ready depends
    // combinationally on out_ready only.
    always_comb begin
        s2Load   = s1Valid_q && (!s2Valid_q || out_ready);
        in_ready = !s1Valid_q || s2Load;
        inXfer   = in_valid && in_ready;
        outXfer  = s2Valid_q && out_ready;
    end

`ifdef LU_CHAIN_EN
    logic [WIDTH-1:0] chain_q, chain_d;

    // The chain register captures every result as the consumer takes it.
    always_comb begin
        chain_d = chain_q;
        if (outXfer) begin
            chain_d = y_q;
        end
    end

    // Operand b comes from the chain register when chaining is requested.
    always_comb begin
        effB = in_chain ? chain_q : in_b;
    end

    // Chain register state, which is cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end
`else
    logic unusedChain;
    assign unusedChain = in_chain;

    // Without chaining, operand b always comes straight from the port.
    always_comb begin
        effB = in_b;
    end
`endif

    // Next state for stage 1: load on accept, empty on advance, else hold.
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Op_d    = s1Op_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        if (inXfer) begin
            s1Valid_d = 1'b1;
            s1Op_d    = in_op;
            s1A_d     = in_a;
            s1B_d     = effB;
        end else if (s2Load) begin
            s1Valid_d = 1'b0;
        end
    end

    // Next state for stage 2: compute the result and flags from stage 1.
    // On a drain with no reload, the data is kept and only valid drops.
    always_comb begin
        stageY    = evalOp(s1Op_q, s1A_q, s1B_q);
        s2Valid_d = s2Valid_q;
        y_d       = y_q;
        zero_d    = zero_q;
        parity_d  = parity_q;
        if (s2Load) begin
            s2Valid_d = 1'b1;
            y_d       = stageY;
            zero_d    = ~|stageY;
            parity_d  = ^stageY;
        end else if (outXfer) begin
            s2Valid_d = 1'b0;
        end
    end

    // Valid bits and output registers. Reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            y_q       <= '0;
            zero_q    <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s2Valid_q <= s2Valid_d;
            y_q       <= y_d;
            zero_q    <= zero_d;
            parity_q  <= parity_d;
        end
    end

    // Stage 1 payload. It is qualified by s1Valid_q and needs no reset.
    always_ff @(posedge clk) begin
        s1Op_q <= s1Op_d;
        s1A_q  <= s1A_d;
        s1B_q  <= s1B_d;
    end

    assign out_valid  = s2Valid_q;
    assign out_y      = y_q;
    assign out_zero   = zero_q;
    assign out_parity = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed, table-driven bench for logic_unit_pipe (WIDTH=8).
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int NVEC  = 14;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_parity;

    int checks;
    int errors;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] expY;
        logic             expZero;
        logic             expParity;
    } vec_t;

    vec_t vecs [NVEC];

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_chain   (in_chain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_parity (out_parity)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand bundle onto the input port.
    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ch);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_chain = ch;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock edge, then sample 1 time unit after it.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Hand-computed vectors: the opcode sweep, followed by flag corners.
        vecs[0]  = '{3'd0, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0};
        vecs[6]  = '{3'd6, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b0};
        vecs[7]  = '{3'd7, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0};
        vecs[8]  = '{3'd1, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{3'd0, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[10] = '{3'd2, 8'h07, 8'h00, 8'h07, 1'b0, 1'b1};
        vecs[11] = '{3'd3, 8'hFE, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[12] = '{3'd4, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{3'd6, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1};

        // Reset held for two cycles.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        stepClk();
        stepClk();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_y", 32'(out_y), 32'h00);
        checkOutput("reset out_zero", 32'(out_zero), 32'd0);
        checkOutput("reset out_parity", 32'(out_parity), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Basic XOR op: the result appears one cycle after acceptance.
        applyStimulus(1'b1, 3'd2, 8'hF0, 8'h3C, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checkOutput("basic latency out_valid", 32'(out_valid), 32'd0);
        stepClk();
        checkOutput("basic out_valid", 32'(out_valid), 32'd1);
        checkOutput("basic out_y", 32'(out_y), 32'hCC);
        checkOutput("basic out_zero", 32'(out_zero), 32'd0);
        checkOutput("basic out_parity", 32'(out_parity), 32'd0);
        out_ready = 1'b1;
        stepClk();
        checkOutput("basic drained", 32'(out_valid), 32'd0);

        // Back-to-back stream of the table vectors, one op per cycle.
        for (int c = 0; c <= NVEC; c++) begin
            if (c < NVEC) begin
                applyStimulus(1'b1, vecs[c].op, vecs[c].a, vecs[c].b, 1'b0);
                checkOutput($sformatf("stream in_ready %0d", c), 32'(in_ready), 32'd1);
            end else begin
                applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
            end
            stepClk();
            if (c >= 1) begin
                checkOutput($sformatf("vec%0d out_valid", c-1), 32'(out_valid), 32'd1);
                checkOutput($sformatf("vec%0d out_y", c-1), 32'(out_y), 32'(vecs[c-1].expY));
                checkOutput($sformatf("vec%0d out_zero", c-1), 32'(out_zero), 32'(vecs[c-1].expZero));
                checkOutput($sformatf("vec%0d out_parity", c-1), 32'(out_parity), 32'(vecs[c-1].expParity));
            end
        end
        stepClk();
        checkOutput("stream drained", 32'(out_valid), 32'd0);

        // Backpressure: two ops buffer, the third stalls, then all drain in order.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 8'h01, 8'h02, 1'b0);
        stepClk();
        applyStimulus(1'b1, 3'd2, 8'hFF, 8'h0F, 1'b0);
        checkOutput("bp second accept", 32'(in_ready), 32'd1);
        stepClk();
        applyStimulus(1'b1, 3'd1, 8'h3C, 8'h0F, 1'b0);
        checkOutput("bp full in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp out_y first", 32'(out_y), 32'h03);
        for (int k = 0; k < 2; k++) begin
            stepClk();
            checkOutput($sformatf("bp stall in_ready %0d", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp stable out_y %0d", k), 32'(out_y), 32'h03);
            checkOutput($sformatf("bp stable out_valid %0d", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
        stepClk();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checkOutput("bp out_y second", 32'(out_y), 32'hF0);
        stepClk();
        checkOutput("bp out_y third", 32'(out_y), 32'h0C);
        checkOutput("bp third valid", 32'(out_valid), 32'd1);
        stepClk();
        checkOutput("bp no duplicate", 32'(out_valid), 32'd0);

        // Reset with two ops buffered discards both.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 8'h11, 8'h22, 1'b0);
        stepClk();
        applyStimulus(1'b1, 3'd0, 8'h44, 8'h88, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        checkOutput("mid full in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        stepClk();
        rst_n = 1'b1;
        checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stepClk();
            checkOutput($sformatf("mid no stale %0d", k), 32'(out_valid), 32'd0);
        end

        // Chain: consume 0x0F, then XOR 0xFF with the chained value.
        applyStimulus(1'b1, 3'd0, 8'h0F, 8'h00, 1'b0);
        stepClk();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        stepClk();
        checkOutput("chain first y", 32'(out_y), 32'h0F);
        stepClk();
        checkOutput("chain first consumed", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 3'd2, 8'hFF, 8'h00, 1'b1);
        stepClk();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        stepClk();
        checkOutput("chain second valid", 32'(out_valid), 32'd1);
`ifdef LU_CHAIN_EN
        checkOutput("chain second y", 32'(out_y), 32'hF0);
`else
        checkOutput("chain second y", 32'(out_y), 32'hFF);
`endif
        stepClk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
